// File: rtl/config_fsm_burst_if.sv
// Configuration write port of the frame-config FSM: word stream in, frame/row
// select and commit strobe out.
interface config_fsm_burst_if #(
    parameter int FRAME_BITS    = 20,
    parameter int ROW_SEL_WIDTH = 5
);
    logic [31:0]              WriteData;
    logic                     WriteStrobe;
    logic                     FSM_Reset;
    logic [FRAME_BITS-1:0]    FrameAddressRegister;
    logic                     LongFrameStrobe;
    logic [ROW_SEL_WIDTH-1:0] RowSelect;
    logic                     Synced;
    logic [15:0]              FrameCount;

    modport master (
        output WriteData, WriteStrobe, FSM_Reset,
        input  FrameAddressRegister, LongFrameStrobe, RowSelect, Synced, FrameCount
    );

    modport slave (
        input  WriteData, WriteStrobe, FSM_Reset,
        output FrameAddressRegister, LongFrameStrobe, RowSelect, Synced, FrameCount
    );
endinterface

// File: rtl/config_fsm_burst.sv
// Frame configuration FSM: sync word, header, then NUM_ROWS+2 words per frame,
// with header-driven bursts of consecutive frames and a delayed commit strobe.
module config_fsm_burst #(
    parameter int          NUM_ROWS      = 16,
    parameter int          ROW_SEL_WIDTH = 5,
    parameter int          FRAME_BITS    = 20,
    parameter logic [31:0] SYNC_WORD     = 32'hFAB0_FAB1,
    parameter int          DESYNC_BIT    = 20,
    parameter int          STROBE_LEN    = 2
) (
    input logic               CLK,
    input logic               resetn,
    config_fsm_burst_if.slave bus
);
    typedef enum logic [1:0] {UNSYNC = 2'd0, SYNCED = 2'd1, DATA = 2'd2} state_t;

    localparam logic [ROW_SEL_WIDTH-1:0] ROW_RELOAD  = ROW_SEL_WIDTH'(NUM_ROWS + 1);
    localparam logic [ROW_SEL_WIDTH-1:0] ROW_ONE     = ROW_SEL_WIDTH'(1);
    localparam logic [3:0]               STROBE_LOAD = 4'(STROBE_LEN);

    state_t                   state, state_nxt;
    logic [ROW_SEL_WIDTH-1:0] row_cnt;
    logic [7:0]               burst_rem;
    logic [FRAME_BITS-1:0]    frame_addr;
    logic [15:0]              frame_count;
    logic                     fsm_reset_prev;
    logic                     abort, hdr_load, commit;
    logic                     commit_p0, commit_p1;
    logic [3:0]               strobe_cnt_p2;

    // Only the 0->1 transition of FSM_Reset aborts; holding it high is harmless.
    assign abort = bus.FSM_Reset & ~fsm_reset_prev;

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) state <= UNSYNC;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        hdr_load  = 1'b0;
        commit    = 1'b0;
        if (abort) begin
            state_nxt = UNSYNC;
        end else if (bus.WriteStrobe) begin
            unique case (state)
                UNSYNC: if (bus.WriteData == SYNC_WORD) state_nxt = SYNCED;
                SYNCED: begin
                    if (bus.WriteData[DESYNC_BIT]) begin
                        state_nxt = UNSYNC;
                    end else begin
                        hdr_load  = 1'b1;
                        state_nxt = DATA;
                    end
                end
                DATA: begin
                    if (row_cnt == '0) begin
                        commit = 1'b1;
                        if (burst_rem == 8'd0) state_nxt = SYNCED;
                    end
                end
                default: state_nxt = UNSYNC;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            row_cnt        <= '0;
            burst_rem      <= '0;
            frame_addr     <= '0;
            frame_count    <= '0;
            fsm_reset_prev <= 1'b0;
        end else begin
            fsm_reset_prev <= bus.FSM_Reset;
            if (abort) begin
                row_cnt   <= '0;
                burst_rem <= '0;
            end else if (hdr_load) begin
                frame_addr <= bus.WriteData[FRAME_BITS-1:0];
                burst_rem  <= bus.WriteData[31:24];
                row_cnt    <= ROW_RELOAD;
            end else if (bus.WriteStrobe && state == DATA) begin
                if (row_cnt != '0) begin
                    row_cnt <= row_cnt - ROW_ONE;
                end else if (burst_rem != 8'd0) begin
                    // Next frame of the burst addresses the following frame-select bit.
                    burst_rem  <= burst_rem - 8'd1;
                    frame_addr <= frame_addr << 1;
                    row_cnt    <= ROW_RELOAD;
                end
            end
            if (commit) frame_count <= frame_count + 16'd1;
        end
    end

    // p0: commit seen, p1: one cycle later, p2: strobe length counter (retriggerable)
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            commit_p0     <= 1'b0;
            commit_p1     <= 1'b0;
            strobe_cnt_p2 <= 4'd0;
        end else begin
            commit_p0 <= commit;
            commit_p1 <= commit_p0;
            if (commit_p1)                 strobe_cnt_p2 <= STROBE_LOAD;
            else if (strobe_cnt_p2 != 4'd0) strobe_cnt_p2 <= strobe_cnt_p2 - 4'd1;
        end
    end

    assign bus.FrameAddressRegister = frame_addr;
    assign bus.FrameCount           = frame_count;
    assign bus.LongFrameStrobe      = (strobe_cnt_p2 != 4'd0);
    assign bus.Synced               = (state != UNSYNC);
    assign bus.RowSelect            = (state == DATA && bus.WriteStrobe) ? row_cnt : '1;
endmodule

// File: doc/config_fsm_burst.md
CONFIG_FSM_BURST -- requirements
Module: config_fsm_burst

Interface
REQ-001 SHALL have parameter NUM_ROWS, default 16: fabric rows per frame.
REQ-002 SHALL have parameter ROW_SEL_WIDTH, default 5: RowSelect width; 2^ROW_SEL_WIDTH-1 > NUM_ROWS+1.
REQ-003 SHALL have parameter FRAME_BITS, default 20: frame-select width; FRAME_BITS <= DESYNC_BIT.
REQ-004 SHALL have parameter SYNC_WORD, default 32'hFAB0_FAB1: synchronisation pattern.
REQ-005 SHALL have parameter DESYNC_BIT, default 20: header bit index requesting desync.
REQ-006 SHALL have parameter STROBE_LEN, default 2, range 1..15: LongFrameStrobe pulse length in cycles.
REQ-007 SHALL have port CLK, input, 1: clock, rising edge.
REQ-008 SHALL have port resetn, input, 1: reset, asynchronous, active-low.
REQ-009 SHALL have port WriteData, input, 32: configuration word.
REQ-010 SHALL have port WriteStrobe, input, 1: WriteData valid this cycle.
REQ-011 SHALL have port FSM_Reset, input, 1: rising edge aborts and returns to unsynced.
REQ-012 SHALL have port FrameAddressRegister, output, FRAME_BITS: current frame select.
REQ-013 SHALL have port LongFrameStrobe, output, 1: frame commit pulse.
REQ-014 SHALL have port RowSelect, output, ROW_SEL_WIDTH: row receiving WriteData.
REQ-015 SHALL have port Synced, output, 1: high in SYNCED or DATA.
REQ-016 SHALL have port FrameCount, output, 16: committed frames since reset, wraps 16'hFFFF->0.

Function
REQ-017 SHALL implement states UNSYNC, SYNCED, DATA; one word consumed per cycle with WriteStrobe=1; WriteStrobe=0 cycles change no state.
REQ-018 UNSYNC: word == SYNC_WORD SHALL move to SYNCED; any other word ignored.
REQ-019 SYNCED: header with WriteData[DESYNC_BIT]=1 SHALL move to UNSYNC and leave FrameAddressRegister unchanged.
REQ-020 SYNCED: header with DESYNC_BIT=0 SHALL load FrameAddressRegister=WriteData[FRAME_BITS-1:0], burst remainder=WriteData[31:24], row counter=NUM_ROWS+1, and move to DATA.
REQ-021 DATA: each accepted word SHALL decrement row counter; word accepted with counter==0 is last word of frame (NUM_ROWS+2 words per frame).
REQ-022 On last word with burst remainder>0: SHALL decrement remainder, shift FrameAddressRegister left by 1 (zero fill, MSB discarded), reload row counter NUM_ROWS+1, remain in DATA.
REQ-023 On last word with burst remainder==0: SHALL move to SYNCED.
REQ-024 Every last word SHALL commit: FrameCount+1 on the same edge; internal commit flag registered that edge.
REQ-025 LongFrameStrobe SHALL rise on the second edge after the last-word edge and stay high exactly STROBE_LEN cycles; commit while high restarts the STROBE_LEN count.
REQ-026 RowSelect SHALL be combinational: row counter when state==DATA and WriteStrobe=1, else all ones.
REQ-027 FSM_Reset rising edge (registered previous value 0, current 1) SHALL force UNSYNC, clear row counter and burst remainder, take priority over any word that cycle, and suppress that cycle's commit.
REQ-028 FSM_Reset edge SHALL NOT truncate a LongFrameStrobe pulse already in progress; FrameAddressRegister and FrameCount hold.
REQ-029 FSM_Reset held high SHALL NOT re-abort; normal operation resumes while high.

Reset
REQ-030 resetn low SHALL asynchronously force UNSYNC, FrameAddressRegister=0, FrameCount=0, LongFrameStrobe=0, counters=0, previous FSM_Reset=0, strobe pipeline clear; Synced=0; RowSelect all ones (DATA not active).
REQ-031 resetn low mid-burst SHALL drop an in-progress LongFrameStrobe immediately.

Verification (NUM_ROWS=4, STROBE_LEN=2 unless stated)
REQ-032 Single frame: SYNC_WORD, header 32'h0000_0001, 6 data words -> RowSelect 5,4,3,2,1,0; FrameAddressRegister=1; LongFrameStrobe high cycles +2,+3 after last word; FrameCount=1; Synced=1.
REQ-033 Burst: header 32'h0200_0004, 18 data words -> 3 commits, FrameAddressRegister 4->8->16, FrameCount=3, end in SYNCED.
REQ-034 Desync: header 32'h0010_0000 -> Synced=0; next non-sync words produce no RowSelect activity; SYNC_WORD re-syncs.
REQ-035 Abort: FSM_Reset rising edge coincident with 6th data word -> no commit, FrameCount unchanged, UNSYNC next cycle; held-high FSM_Reset then SYNC_WORD resyncs.
REQ-036 STROBE_LEN=8, NUM_ROWS=2, back-to-back burst -> LongFrameStrobe continuous, falls 8 cycles after final retrigger.
REQ-037 Gaps and reset: random WriteStrobe=0 gaps give identical results to REQ-033; resetn low mid-burst clears all outputs asynchronously.
